seq_rshift: RTL

//  Multi-cycle right shifter/rotator: the reverse-direction counterpart of the 8-bit combinational left shifter.

---
 rtl/shift_pkg.sv | 12 +
 rtl/rshift_step.sv | 18 +
 rtl/seq_rshift.sv | 94 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM state type and default width for seq_rshift
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } rshift_state_t;

  localparam int SHIFT_WIDTH_DEF = 8;

endpackage

// File: rtl/rshift_step.sv
// rtl/rshift_step.sv - one-position right step; rotate when SEQ_RSHIFT_ROTATE_EN is defined, else zero-fill shift
module rshift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Drop bit 0 and refill the MSB, either with the outgoing bit or with zero
  always_comb begin
`ifdef SEQ_RSHIFT_ROTATE_EN
    y = {x[0], x[WIDTH-1:1]};
`else
    y = {1'b0, x[WIDTH-1:1]};
`endif
  end

endmodule

// File: rtl/seq_rshift.sv
// rtl/seq_rshift.sv - serial right shifter/rotator, one bit per clock, valid/ready in and out (rotate via SEQ_RSHIFT_ROTATE_EN)
module seq_rshift
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
);

  rshift_state_t    state;
  rshift_state_t    state_nxt;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] q_step;

  rshift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .x(q),
    .y(q_step)
  );

  // State register; reset drops any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; ready and valid are pure decodes of state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (shift == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == SHW'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Data path: load on accept, step and count down while shifting, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            q   <= in;
            cnt <= shift;
          end
        end
        S_SHIFT: begin
          q   <= q_step;
          cnt <= cnt - SHW'(1);
        end
        default: begin
          q   <= q;
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule
